datapath_trace_checker: RTL and testbench
=========================================

Name: datapath_trace_checker

Overview:
- Self-checking consumer of the single-cycle datapath's observable outputs: nextPC, ALUResult and instruction.
- Holds an expected commit trace in internal storage and compares it against the datapath's per-cycle outputs.
- Reports pass/fail plus the first mismatch, so long clock sequences need no manual reading of $monitor dumps.
- Instantiated next to the datapath in benches, with outputs wired in parallel.

Parameters:
TRACE_DEPTH, 64, number of expected-trace entries
ADDR_W, 6, index width; must equal clog2(TRACE_DEPTH)
TIMEOUT_CYCLES, 16, maximum consecutive RUN cycles with sample_en low before timeout failure

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high
wr_en  input  1  write one expected entry
wr_addr  input  ADDR_W  entry index
wr_pc  input  64  expected nextPC
wr_alu  input  64  expected ALUResult
wr_instr  input  32  expected instruction
start  input  1  begin checking (pulse)
trace_len  input  ADDR_W+1  number of entries to check, sampled on start
cmp_mask  input  3  bit2 instr, bit1 pc, bit0 alu; sampled on start
sample_en  input  1  compare this cycle
nextPC  input  64  observed datapath PC
ALUResult  input  64  observed ALU result
instruction  input  32  observed instruction
busy  output  1  high in RUN
done  output  1  high in PASS or FAIL
pass  output  1  high in PASS
fail  output  1  high in FAIL
timeout  output  1  FAIL was caused by timeout
match_count  output  ADDR_W+1  entries matched so far
mismatch_idx  output  ADDR_W  index of the failing entry
mismatch_field  output  3  per-field miscompare bits, same order as cmp_mask
obs_pc  output  64  captured observed nextPC at failure
obs_alu  output  64  captured observed ALUResult at failure
obs_instr  output  32  captured observed instruction at failure

Behaviour:
- Reset (sync, high): state IDLE; every output 0; index, idle counter and latched len/mask cleared. Trace storage is NOT cleared.
- States: IDLE, RUN, PASS, FAIL.
- Writes:
  - Accepted when wr_en=1 in IDLE, PASS or FAIL; ignored in RUN.
  - A written entry is readable on the next cycle.
- IDLE, PASS or FAIL with start=1:
  - Latch len = min(trace_len, TRACE_DEPTH) and the mask; clear index, match_count and all capture outputs.
  - If len=0, go to PASS next cycle; otherwise go to RUN.
  - start and wr_en together: the write happens, and checking starts on the next cycle with the new data visible.
- RUN, sample_en=1:
  - Compare the enabled fields of entry[index] against the observed inputs combinationally; the result is registered at this edge.
  - All enabled fields equal: match_count+1, index+1. If index was len-1, go to PASS.
  - Any enabled field differs: go to FAIL. mismatch_idx=index; mismatch_field = per-field inequality AND mask; obs_* capture the inputs; match_count holds.
  - cmp_mask=000: every sample matches.
- RUN, sample_en=0: idle counter +1. When it reaches TIMEOUT_CYCLES, go to FAIL with timeout=1, mismatch_field=000, mismatch_idx=index. The counter clears on any sample.
- Latency: pass or fail is asserted the first cycle after the deciding sample edge.
- start in RUN is ignored.
- PASS and FAIL hold until reset or a new start.
- reset during RUN: IDLE next cycle, outputs 0; stored trace remains valid for a re-run.
- Output relations: busy = (state==RUN); done = pass|fail; pass and fail are never both 1.

Test Plan:
- Load 4 entries (pc 0,4,8,12; alu 5,6,7,8; instr 0x00500093...); start len=4, mask=111; drive matching values for 4 sampled cycles -> pass=1 on cycle 5, match_count=4, fail=0.
- Same trace, entry 2 observed with alu=9 -> fail=1, mismatch_idx=2, mismatch_field=001, obs_alu=9, match_count=2.
- Same mismatch with mask=110 -> no failure; pass after 4 samples.
- start with len=4, then sample_en=0 for 16 cycles -> fail=1, timeout=1, mismatch_idx=0; repeat with a sample at cycle 10 -> no timeout before cycle 26.
- reset asserted after 2 samples -> all outputs 0 next cycle; restart without reloading -> pass with the same stored trace.
- trace_len=0 -> pass the cycle after start; trace_len=65 with depth 64 -> clamps, pass after 64 samples; wr_en in RUN -> entry unchanged.

Source files
------------

// File: rtl/datapath_trace_checker.sv
// datapath_trace_checker
//
// Compares a single-cycle datapath's observable outputs against an expected
// commit trace. The trace is loaded through the wr_* port, and a run begins
// with a start pulse. Each cycle with sample_en high compares the enabled
// fields of the current entry with the observed values. The block stops at
// the first mismatch, at a timeout, or after trace_len matching entries, and
// then holds its verdict.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   wr_en/wr_addr/wr_*  load one expected entry (ignored while busy)
//   start, trace_len,   begin a run; length and field mask are sampled
//   cmp_mask              on the start cycle (mask: bit2 instr, bit1 pc,
//                         bit0 alu)
//   sample_en, nextPC,  observed datapath outputs and their qualifier
//   ALUResult,
//   instruction
//   busy/done/pass/fail run status; pass and fail are mutually exclusive
//   timeout             the failure came from too many idle cycles
//   match_count         entries matched so far in this run
//   mismatch_idx/_field failing entry and per-field miscompare bits
//   obs_*               observed values captured at a data mismatch
//
// Handshake: the bench asserts sample_en for exactly the cycles that carry a
// committed instruction. Each such cycle consumes one trace entry, and there
// is no backpressure. The verdict appears the cycle after the deciding edge.
module datapath_trace_checker #(
  parameter int TRACE_DEPTH    = 64,
  parameter int ADDR_W         = 6,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [63:0]       wr_pc,
  input  logic [63:0]       wr_alu,
  input  logic [31:0]       wr_instr,
  input  logic              start,
  input  logic [ADDR_W:0]   trace_len,
  input  logic [2:0]        cmp_mask,
  input  logic              sample_en,
  input  logic [63:0]       nextPC,
  input  logic [63:0]       ALUResult,
  input  logic [31:0]       instruction,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [ADDR_W:0]   match_count,
  output logic [ADDR_W-1:0] mismatch_idx,
  output logic [2:0]        mismatch_field,
  output logic [63:0]       obs_pc,
  output logic [63:0]       obs_alu,
  output logic [31:0]       obs_instr
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(TRACE_DEPTH);
  localparam logic [CNT_W-1:0] TMO_L   = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t state_q, state_d;

  // Expected trace. Reset leaves it alone, so a run can be repeated after a
  // reset without reloading.
  logic [63:0] trace_pc    [TRACE_DEPTH];
  logic [63:0] trace_alu   [TRACE_DEPTH];
  logic [31:0] trace_instr [TRACE_DEPTH];

  logic [ADDR_W:0]   len_q, len_d;
  logic [2:0]        mask_q, mask_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  idle_q, idle_d;
  logic [ADDR_W:0]   match_count_q, match_count_d;
  logic              timeout_q, timeout_d;
  logic [ADDR_W-1:0] mismatch_idx_q, mismatch_idx_d;
  logic [2:0]        mismatch_field_q, mismatch_field_d;
  logic [63:0]       obs_pc_q, obs_pc_d;
  logic [63:0]       obs_alu_q, obs_alu_d;
  logic [31:0]       obs_instr_q, obs_instr_d;

  logic [63:0]       exp_pc, exp_alu;
  logic [31:0]       exp_instr;
  logic [2:0]        field_diff;
  logic [ADDR_W:0]   start_len;
  logic [ADDR_W:0]   len_m1;
  logic              last_entry;
  logic [CNT_W-1:0]  idle_inc;
  logic              timeout_hit;

  // Trace storage write port. While a run is in progress the trace is
  // frozen.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q != S_RUN)) begin
      trace_pc[wr_addr]    <= wr_pc;
      trace_alu[wr_addr]   <= wr_alu;
      trace_instr[wr_addr] <= wr_instr;
    end
  end

  // Compare path and derived conditions.
  always_comb begin
    exp_pc      = trace_pc[idx_q];
    exp_alu     = trace_alu[idx_q];
    exp_instr   = trace_instr[idx_q];
    field_diff  = {(instruction != exp_instr), (nextPC != exp_pc),
                   (ALUResult != exp_alu)} & mask_q;
    start_len   = (trace_len > DEPTH_L) ? DEPTH_L : trace_len;
    len_m1      = len_q - (ADDR_W + 1)'(1);
    last_entry  = ({1'b0, idx_q} == len_m1);
    idle_inc    = idle_q + CNT_W'(1);
    timeout_hit = (idle_inc == TMO_L);
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (sample_en) begin
          if (field_diff != 3'b000) begin
            state_d = S_FAIL;
          end else if (last_entry) begin
            state_d = S_PASS;
          end
        end else if (timeout_hit) begin
          state_d = S_FAIL;
        end
      end
      default: begin
        if (start) begin
          state_d = (start_len == '0) ? S_PASS : S_RUN;
        end
      end
    endcase
  end

  // FSM: status outputs, decoded straight from the state.
  always_comb begin
    busy = (state_q == S_RUN);
    pass = (state_q == S_PASS);
    fail = (state_q == S_FAIL);
    done = (state_q == S_PASS) || (state_q == S_FAIL);
  end

  // Run bookkeeping and failure capture.
  always_comb begin
    len_d            = len_q;
    mask_d           = mask_q;
    idx_d            = idx_q;
    idle_d           = idle_q;
    match_count_d    = match_count_q;
    timeout_d        = timeout_q;
    mismatch_idx_d   = mismatch_idx_q;
    mismatch_field_d = mismatch_field_q;
    obs_pc_d         = obs_pc_q;
    obs_alu_d        = obs_alu_q;
    obs_instr_d      = obs_instr_q;
    if (state_q == S_RUN) begin
      if (sample_en) begin
        idle_d = '0;
        if (field_diff == 3'b000) begin
          // idx may wrap on the final entry of a full-depth trace, but the
          // FSM leaves RUN at that same edge, so the wrap is never used.
          match_count_d = match_count_q + (ADDR_W + 1)'(1);
          idx_d         = idx_q + ADDR_W'(1);
        end else begin
          mismatch_idx_d   = idx_q;
          mismatch_field_d = field_diff;
          obs_pc_d         = nextPC;
          obs_alu_d        = ALUResult;
          obs_instr_d      = instruction;
        end
      end else begin
        idle_d = idle_inc;
        if (timeout_hit) begin
          timeout_d        = 1'b1;
          mismatch_idx_d   = idx_q;
          mismatch_field_d = 3'b000;
        end
      end
    end else if (start) begin
      len_d            = start_len;
      mask_d           = cmp_mask;
      idx_d            = '0;
      idle_d           = '0;
      match_count_d    = '0;
      timeout_d        = 1'b0;
      mismatch_idx_d   = '0;
      mismatch_field_d = 3'b000;
      obs_pc_d         = '0;
      obs_alu_d        = '0;
      obs_instr_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q            <= '0;
      mask_q           <= 3'b000;
      idx_q            <= '0;
      idle_q           <= '0;
      match_count_q    <= '0;
      timeout_q        <= 1'b0;
      mismatch_idx_q   <= '0;
      mismatch_field_q <= 3'b000;
      obs_pc_q         <= '0;
      obs_alu_q        <= '0;
      obs_instr_q      <= '0;
    end else begin
      len_q            <= len_d;
      mask_q           <= mask_d;
      idx_q            <= idx_d;
      idle_q           <= idle_d;
      match_count_q    <= match_count_d;
      timeout_q        <= timeout_d;
      mismatch_idx_q   <= mismatch_idx_d;
      mismatch_field_q <= mismatch_field_d;
      obs_pc_q         <= obs_pc_d;
      obs_alu_q        <= obs_alu_d;
      obs_instr_q      <= obs_instr_d;
    end
  end

  assign timeout        = timeout_q;
  assign match_count    = match_count_q;
  assign mismatch_idx   = mismatch_idx_q;
  assign mismatch_field = mismatch_field_q;
  assign obs_pc         = obs_pc_q;
  assign obs_alu        = obs_alu_q;
  assign obs_instr      = obs_instr_q;

endmodule

// File: tb/tb_datapath_trace_checker.sv
// Bench for datapath_trace_checker: directed scenarios plus randomized runs.
// Expected verdicts come from a sequential reference walk over the planned
// observation list. The monitor compares them when done appears.
module tb_datapath_trace_checker;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int TMO   = 16;
  localparam int MAXC  = 512;

  // Clock and reset block
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          wr_en, start, sample_en;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_pc, wr_alu, nextPC, ALUResult;
  logic [31:0]   wr_instr, instruction;
  logic [AW:0]   trace_len;
  logic [2:0]    cmp_mask;
  logic          busy, done, pass, fail, timeout;
  logic [AW:0]   match_count;
  logic [AW-1:0] mismatch_idx;
  logic [2:0]    mismatch_field;
  logic [63:0]   obs_pc, obs_alu;
  logic [31:0]   obs_instr;

  datapath_trace_checker #(
    .TRACE_DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_pc(wr_pc), .wr_alu(wr_alu), .wr_instr(wr_instr),
    .start(start), .trace_len(trace_len), .cmp_mask(cmp_mask),
    .sample_en(sample_en), .nextPC(nextPC), .ALUResult(ALUResult),
    .instruction(instruction), .busy(busy), .done(done), .pass(pass),
    .fail(fail), .timeout(timeout), .match_count(match_count),
    .mismatch_idx(mismatch_idx), .mismatch_field(mismatch_field),
    .obs_pc(obs_pc), .obs_alu(obs_alu), .obs_instr(obs_instr)
  );

  // Scoreboard state
  typedef struct packed {
    logic          pass;
    logic          timeout;
    logic [AW:0]   match_count;
    logic [AW-1:0] idx;
    logic [2:0]    field;
    logic [63:0]   pc;
    logic [63:0]   alu;
    logic [31:0]   instr;
    logic [31:0]   cycle;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          issued   = 0;
  int          seen     = 0;
  int unsigned arm_cyc  = 0;

  // Reference trace memory and planned observation list
  logic [63:0] ref_pc[DEPTH];
  logic [63:0] ref_alu[DEPTH];
  logic [31:0] ref_in[DEPTH];
  bit          o_se[MAXC];
  bit          o_wr[MAXC];
  logic [63:0] o_pc[MAXC];
  logic [63:0] o_alu[MAXC];
  logic [31:0] o_in[MAXC];
  int          n_obs = 0;

  // Write planned for the start cycle itself
  bit          sw_en = 1'b0;
  logic [AW-1:0] sw_addr;
  logic [63:0] sw_pc, sw_alu;
  logic [31:0] sw_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: walk the observation list cycle by cycle against the
  // expected trace and report how and when the run ends.
  function automatic exp_t model(input int len, input logic [2:0] mask);
    exp_t e = '0;
    int idx = 0;
    int idle = 0;
    logic [2:0] bad;
    if (len == 0) begin
      e.pass = 1'b1;
      return e;
    end
    for (int t = 0; t < n_obs; t++) begin
      if (o_se[t]) begin
        idle = 0;
        bad[0] = (o_alu[t] != ref_alu[idx[AW-1:0]]);
        bad[1] = (o_pc[t]  != ref_pc[idx[AW-1:0]]);
        bad[2] = (o_in[t]  != ref_in[idx[AW-1:0]]);
        bad = bad & mask;
        if (bad != 3'b000) begin
          e.idx = idx[AW-1:0];
          e.field = bad;
          e.pc = o_pc[t];
          e.alu = o_alu[t];
          e.instr = o_in[t];
          e.match_count = (AW + 1)'(idx);
          e.cycle = 32'(t + 1);
          return e;
        end
        idx++;
        if (idx == len) begin
          e.pass = 1'b1;
          e.match_count = (AW + 1)'(len);
          e.cycle = 32'(t + 1);
          return e;
        end
      end else begin
        idle++;
        if (idle == TMO) begin
          e.timeout = 1'b1;
          e.idx = idx[AW-1:0];
          e.match_count = (AW + 1)'(idx);
          e.cycle = 32'(t + 1);
          return e;
        end
      end
    end
    e.cycle = '1;
    return e;
  endfunction

  // Monitor: pops an expectation when a verdict is presented.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && (issued != seen) && (cyc >= arm_cyc) && done) begin
      seen = seen + 1;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL exp_queue: got verdict expected none queued");
      end else begin
        e = exp_q.pop_front();
        check("verdict_cycle", 64'(cyc), 64'(e.cycle));
        check("pass", 64'(pass), 64'(e.pass));
        check("fail", 64'(fail), 64'(!e.pass));
        check("busy_at_done", 64'(busy), 64'(0));
        check("timeout", 64'(timeout), 64'(e.timeout));
        check("match_count", 64'(match_count), 64'(e.match_count));
        if (!e.pass) begin
          check("mismatch_idx", 64'(mismatch_idx), 64'(e.idx));
          check("mismatch_field", 64'(mismatch_field), 64'(e.field));
          if (!e.timeout) begin
            check("obs_pc", obs_pc, e.pc);
            check("obs_alu", obs_alu, e.alu);
            check("obs_instr", 64'(obs_instr), 64'(e.instr));
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_entry(input int a, input logic [63:0] pc, input logic [63:0] alu,
                            input logic [31:0] in);
    wr_en = 1'b1;
    wr_addr = a[AW-1:0];
    wr_pc = pc;
    wr_alu = alu;
    wr_instr = in;
    ref_pc[a[AW-1:0]] = pc;
    ref_alu[a[AW-1:0]] = alu;
    ref_in[a[AW-1:0]] = in;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic plan_start_write(input int a, input logic [63:0] pc, input logic [63:0] alu,
                                  input logic [31:0] in);
    sw_en = 1'b1;
    sw_addr = a[AW-1:0];
    sw_pc = pc;
    sw_alu = alu;
    sw_in = in;
    ref_pc[a[AW-1:0]] = pc;
    ref_alu[a[AW-1:0]] = alu;
    ref_in[a[AW-1:0]] = in;
  endtask

  task automatic add_sample(input int k);
    o_se[n_obs] = 1'b1;
    o_wr[n_obs] = 1'b0;
    o_pc[n_obs] = ref_pc[k[AW-1:0]];
    o_alu[n_obs] = ref_alu[k[AW-1:0]];
    o_in[n_obs] = ref_in[k[AW-1:0]];
    n_obs++;
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) begin
      o_se[n_obs] = 1'b0;
      o_wr[n_obs] = 1'b0;
      o_pc[n_obs] = {$urandom, $urandom};
      o_alu[n_obs] = {$urandom, $urandom};
      o_in[n_obs] = $urandom;
      n_obs++;
    end
  endtask

  task automatic gen_obs(input int len);
    int k = 0;
    int f;
    int b;
    n_obs = 0;
    while ((k < len + 2) && (n_obs < MAXC - 20)) begin
      if ($urandom_range(0, 19) == 0) begin
        add_idle(15);
      end else if ($urandom_range(0, 3) == 0) begin
        add_idle(1);
      end else begin
        add_sample(k % DEPTH);
        if ($urandom_range(0, 29) == 0) begin
          f = $urandom_range(0, 2);
          b = $urandom_range(0, 31);
          if (f == 0) o_alu[n_obs-1][b] = ~o_alu[n_obs-1][b];
          else if (f == 1) o_pc[n_obs-1][b] = ~o_pc[n_obs-1][b];
          else o_in[n_obs-1][b] = ~o_in[n_obs-1][b];
        end
        k++;
      end
      if ($urandom_range(0, 7) == 0) o_wr[n_obs-1] = 1'b1;
    end
  endtask

  // Issue one run: compute the expectation, queue it, then drive the list.
  task automatic run_test(input int tlen, input logic [2:0] mask);
    exp_t e;
    int len;
    int steps;
    len = (tlen > DEPTH) ? DEPTH : tlen;
    e = model(len, mask);
    if (e.cycle == '1) begin
      n_checks++;
      n_fail++;
      $display("FAIL plan_undecided: got no verdict expected one within %0d cycles", n_obs);
      sw_en = 1'b0;
      return;
    end
    steps = int'(e.cycle);
    start = 1'b1;
    trace_len = (AW + 1)'(tlen);
    cmp_mask = mask;
    wr_en = sw_en;
    wr_addr = sw_addr;
    wr_pc = sw_pc;
    wr_alu = sw_alu;
    wr_instr = sw_in;
    e.cycle = e.cycle + 32'(cyc) + 32'd1;
    exp_q.push_back(e);
    arm_cyc = cyc + 1;
    issued = issued + 1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    sw_en = 1'b0;
    trace_len = (AW + 1)'($urandom_range(0, 127));
    for (int t = 0; t < steps; t++) begin
      sample_en = o_se[t];
      nextPC = o_pc[t];
      ALUResult = o_alu[t];
      instruction = o_in[t];
      wr_en = o_wr[t];
      wr_addr = AW'($urandom_range(0, DEPTH - 1));
      wr_pc = {$urandom, $urandom};
      wr_alu = {$urandom, $urandom};
      wr_instr = $urandom;
      tick();
    end
    sample_en = 1'b0;
    wr_en = 1'b0;
    for (int w = 0; w < 40; w++) begin
      if (issued == seen) break;
      tick();
    end
    if (issued != seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL verdict_timeout: got no done expected done at cycle %0d", e.cycle);
      exp_q.delete();
      issued = seen;
    end
    tick();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_pass"}, 64'(pass), 64'(0));
    check({tag, "_fail"}, 64'(fail), 64'(0));
    check({tag, "_timeout"}, 64'(timeout), 64'(0));
    check({tag, "_match_count"}, 64'(match_count), 64'(0));
    check({tag, "_mismatch_idx"}, 64'(mismatch_idx), 64'(0));
    check({tag, "_mismatch_field"}, 64'(mismatch_field), 64'(0));
    check({tag, "_obs_pc"}, obs_pc, 64'(0));
    check({tag, "_obs_alu"}, obs_alu, 64'(0));
    check({tag, "_obs_instr"}, 64'(obs_instr), 64'(0));
  endtask

  task automatic load_basic();
    load_entry(0, 64'd0,  64'd5, 32'h0050_0093);
    load_entry(1, 64'd4,  64'd6, 32'h0060_0113);
    load_entry(2, 64'd8,  64'd7, 32'h0070_0193);
    load_entry(3, 64'd12, 64'd8, 32'h0080_0213);
  endtask

  // Stimulus
  initial begin
    reset = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_pc = '0; wr_alu = '0; wr_instr = '0;
    start = 1'b0; trace_len = '0; cmp_mask = 3'b000;
    sample_en = 1'b0; nextPC = '0; ALUResult = '0; instruction = '0;
    sw_addr = '0; sw_pc = '0; sw_alu = '0; sw_in = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check_zero_outputs("reset");

    load_basic();

    // Full match, then a data mismatch, then the same mismatch masked off.
    n_obs = 0;
    for (int k = 0; k < 4; k++) add_sample(k);
    run_test(4, 3'b111);

    n_obs = 0;
    for (int k = 0; k < 4; k++) add_sample(k);
    o_alu[2] = 64'd9;
    run_test(4, 3'b111);

    n_obs = 0;
    for (int k = 0; k < 4; k++) add_sample(k);
    o_alu[2] = 64'd9;
    run_test(4, 3'b110);

    // Timeout with no samples, and a sample that restarts the idle count.
    n_obs = 0;
    add_idle(20);
    run_test(4, 3'b111);

    n_obs = 0;
    add_idle(9);
    add_sample(0);
    add_idle(20);
    run_test(4, 3'b111);

    // Zero-length run.
    n_obs = 0;
    add_idle(2);
    run_test(0, 3'b111);

    // Reset in the middle of a run, then rerun from the stored trace.
    start = 1'b1; trace_len = 7'd4; cmp_mask = 3'b111;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sample_en = 1'b1;
      nextPC = ref_pc[k];
      ALUResult = ref_alu[k];
      instruction = ref_in[k];
      tick();
    end
    sample_en = 1'b0;
    check("mid_run_busy", 64'(busy), 64'(1));
    check("mid_run_match_count", 64'(match_count), 64'(2));
    reset = 1'b1;
    tick();
    check_zero_outputs("mid_reset");
    reset = 1'b0;
    tick();
    n_obs = 0;
    for (int k = 0; k < 4; k++) add_sample(k);
    run_test(4, 3'b111);

    // Writes during a run must not reach the trace.
    n_obs = 0;
    for (int k = 0; k < 4; k++) begin
      add_sample(k);
      o_wr[n_obs-1] = 1'b1;
    end
    run_test(4, 3'b111);
    n_obs = 0;
    for (int k = 0; k < 4; k++) add_sample(k);
    run_test(4, 3'b111);

    // Write on the start cycle is visible to the first compare.
    plan_start_write(0, 64'h100, 64'h55, 32'h00a0_0513);
    n_obs = 0;
    for (int k = 0; k < 4; k++) add_sample(k);
    run_test(4, 3'b111);

    // Full-depth trace with an over-range length, which clamps to the depth.
    for (int a = 0; a < DEPTH; a++) begin
      load_entry(a, {$urandom, $urandom}, {$urandom, $urandom}, $urandom);
    end
    n_obs = 0;
    for (int k = 0; k < DEPTH; k++) add_sample(k);
    run_test(DEPTH + 1, 3'b111);

    // Randomized runs.
    for (int r = 0; r < 40; r++) begin
      int len;
      len = $urandom_range(0, 70);
      if ($urandom_range(0, 3) == 0) begin
        plan_start_write($urandom_range(0, DEPTH - 1), {$urandom, $urandom},
                         {$urandom, $urandom}, $urandom);
      end
      gen_obs((len > DEPTH) ? DEPTH : len);
      run_test(len, 3'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of test expected finish before 5 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
